bus_arbiter: RTL and testbench

//  Round-robin arbiter for the 4-master shared bus. Sits upstream of the slave

---
 rtl/bus_arbiter_pkg.sv | 41 ++++
 rtl/bus_arbiter_if.sv | 33 +++
 rtl/bus_arbiter_rr_pick.sv | 34 +++
 rtl/bus_arbiter.sv | 89 ++++++++
 tb/tb_bus_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// bus_arbiter_pkg : shared bus constants, owner type and grant decode helper
// Revision 1.0
// ============================================================================
package bus_arbiter_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int BUS_MASTER_CH = 4;
  localparam int BUS_OWNER_W   = 2;

  typedef logic [BUS_OWNER_W-1:0] owner_t;

  localparam owner_t BUS_OWNER_MASTER_0 = 2'd0;
  localparam owner_t BUS_OWNER_MASTER_1 = 2'd1;
  localparam owner_t BUS_OWNER_MASTER_2 = 2'd2;
  localparam owner_t BUS_OWNER_MASTER_3 = 2'd3;

  // OWNED: owner still requests; PARKED: owner has let go, bus idles on it
  typedef enum logic {
    BUS_OWNED  = 1'b0,
    BUS_PARKED = 1'b1
  } bus_state_e;

  function automatic logic [BUS_MASTER_CH-1:0] grant_decode(input owner_t owner);
    logic [BUS_MASTER_CH-1:0] g;
    g = {BUS_MASTER_CH{DISABLE_}};
    case (owner)
      BUS_OWNER_MASTER_0: g[0] = ENABLE_;
      BUS_OWNER_MASTER_1: g[1] = ENABLE_;
      BUS_OWNER_MASTER_2: g[2] = ENABLE_;
      BUS_OWNER_MASTER_3: g[3] = ENABLE_;
      default:            g[0] = ENABLE_;
    endcase
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// bus_arbiter_if : request/grant/ready bundle between masters and the arbiter
// Revision 1.0
// ============================================================================
interface bus_arbiter_if;

  logic                     m0_req_;
  logic                     m1_req_;
  logic                     m2_req_;
  logic                     m3_req_;
  logic                     m_rdy_;
  logic                     m0_grnt_;
  logic                     m1_grnt_;
  logic                     m2_grnt_;
  logic                     m3_grnt_;
  bus_arbiter_pkg::owner_t  owner;
  logic                     bus_err_;

  // Arbiter side
  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_, m_rdy_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, bus_err_
  );

  // Requesting masters plus the slave read mux
  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_, m_rdy_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, bus_err_
  );

endinterface
`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// bus_arbiter_rr_pick : round-robin scan from start+1, start itself checked last
// Revision 1.0
// ============================================================================
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [BUS_MASTER_CH-1:0] req_,
  input  owner_t                   start,
  input  logic                     exclude_self,
  output logic                     valid,
  output owner_t                   winner
);

  owner_t idx;

  always_comb begin
    valid  = 1'b0;
    winner = start;
    idx    = start;
    // Index wraps naturally in the 2-bit owner type; i == 4 lands back on start
    for (int i = 1; i <= BUS_MASTER_CH; i++) begin
      idx = start + owner_t'(i);
      if (!valid && (req_[idx] == ENABLE_) &&
          !(exclude_self && (i == BUS_MASTER_CH))) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// bus_arbiter : 4-master round-robin bus arbiter with parked grant and watchdog
// Revision 1.0
// ============================================================================
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] WDOG_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] WDOG_MAX  = '1;
  localparam logic             WDOG_ON   = (TIMEOUT > 0);

  logic [BUS_MASTER_CH-1:0] req_vec;
  owner_t                   owner_q, owner_d;
  logic [BUS_MASTER_CH-1:0] grnt_q, grnt_d;
  logic                     bus_err_q, bus_err_d;
  logic [CNT_W-1:0]         wdog_q, wdog_d;

  bus_state_e               bus_state;
  logic                     waiting;
  logic                     expire;
  logic                     pick_valid;
  owner_t                   pick_winner;

  assign req_vec   = {bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
  assign bus_state = (req_vec[owner_q] == ENABLE_) ? BUS_OWNED : BUS_PARKED;
  assign waiting   = (bus_state == BUS_OWNED) && (bus.m_rdy_ == DISABLE_);
  assign expire    = WDOG_ON && waiting && (wdog_q == WDOG_LAST);

  // While owned, only a watchdog expiry consults the picker, and then the
  // stuck owner must not win itself back.
  bus_arbiter_rr_pick u_rr_pick (
    .req_         (req_vec),
    .start        (owner_q),
    .exclude_self (bus_state == BUS_OWNED),
    .valid        (pick_valid),
    .winner       (pick_winner)
  );

  always_comb begin
    owner_d   = owner_q;
    bus_err_d = DISABLE_;
    wdog_d    = '0;
    if (bus_state == BUS_PARKED) begin
      if (pick_valid) begin
        owner_d = pick_winner;
      end
    end else if (expire) begin
      bus_err_d = ENABLE_;
      if (pick_valid) begin
        owner_d = pick_winner;
      end
    end else if (WDOG_ON && waiting) begin
      wdog_d = (wdog_q != WDOG_MAX) ? (wdog_q + CNT_W'(1)) : wdog_q;
    end
    grnt_d = grant_decode(owner_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q   <= BUS_OWNER_MASTER_0;
      grnt_q    <= grant_decode(BUS_OWNER_MASTER_0);
      bus_err_q <= DISABLE_;
      wdog_q    <= '0;
    end else begin
      owner_q   <= owner_d;
      grnt_q    <= grnt_d;
      bus_err_q <= bus_err_d;
      wdog_q    <= wdog_d;
    end
  end

  assign bus.m0_grnt_ = grnt_q[0];
  assign bus.m1_grnt_ = grnt_q[1];
  assign bus.m2_grnt_ = grnt_q[2];
  assign bus.m3_grnt_ = grnt_q[3];
  assign bus.owner    = owner_q;
  assign bus.bus_err_ = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bus_arbiter : directed vector bench for bus_arbiter (TIMEOUT=8 and TIMEOUT=0)
// Revision 1.0
// ============================================================================
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  typedef struct {
    logic [3:0] req_;
    logic [1:0] owner;
    logic [3:0] grnt_;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_;
  logic       rdy_;
  int         n_vec = 0;
  int         n_bad = 0;
  logic       off_err_seen = 1'b0;
  vec_t       tbl [14];

  always #5 clk = ~clk;

  bus_arbiter_if u_if ();
  bus_arbiter_if u_if_off ();

  assign u_if.m0_req_     = req_[0];
  assign u_if.m1_req_     = req_[1];
  assign u_if.m2_req_     = req_[2];
  assign u_if.m3_req_     = req_[3];
  assign u_if.m_rdy_      = rdy_;
  assign u_if_off.m0_req_ = req_[0];
  assign u_if_off.m1_req_ = req_[1];
  assign u_if_off.m2_req_ = req_[2];
  assign u_if_off.m3_req_ = req_[3];
  assign u_if_off.m_rdy_  = rdy_;

  bus_arbiter #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (u_if.slave)
  );

  bus_arbiter #(.TIMEOUT(0), .CNT_W(4)) dut_off (
    .clk   (clk),
    .reset (rst),
    .bus   (u_if_off.slave)
  );

  wire [3:0] grnt_ = {u_if.m3_grnt_, u_if.m2_grnt_, u_if.m1_grnt_, u_if.m0_grnt_};

  function automatic logic [3:0] low_hot(input int o);
    logic [3:0] g;
    g = 4'b1111;
    g[o] = 1'b0;
    return g;
  endfunction

  // Exactly one grant low on every cycle; also watch the watchdog-off instance
  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      if (!$onehot(~grnt_)) begin
        n_bad++;
        $display("FAIL one_grant: got grnt_=%b, required exactly one low bit", grnt_);
      end
      if (u_if_off.bus_err_ !== 1'b1) off_err_seen = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int eo, input logic [3:0] eg, input logic ee);
    n_vec++;
    if (u_if.owner !== 2'(eo) || grnt_ !== eg || u_if.bus_err_ !== ee) begin
      n_bad++;
      $display("FAIL %s: got owner=%0d grnt_=%b bus_err_=%b, required owner=%0d grnt_=%b bus_err_=%b",
               nm, u_if.owner, grnt_, u_if.bus_err_, eo, eg, ee);
    end
  endtask

  initial begin
    tbl[0]  = '{4'b1110, 2'd0, 4'b1110};
    tbl[1]  = '{4'b1000, 2'd0, 4'b1110};
    tbl[2]  = '{4'b1001, 2'd1, 4'b1101};
    tbl[3]  = '{4'b1001, 2'd1, 4'b1101};
    tbl[4]  = '{4'b1011, 2'd2, 4'b1011};
    tbl[5]  = '{4'b1111, 2'd2, 4'b1011};
    tbl[6]  = '{4'b0110, 2'd3, 4'b0111};
    tbl[7]  = '{4'b1110, 2'd0, 4'b1110};
    tbl[8]  = '{4'b0000, 2'd0, 4'b1110};
    tbl[9]  = '{4'b0001, 2'd1, 4'b1101};
    tbl[10] = '{4'b1111, 2'd1, 4'b1101};
    tbl[11] = '{4'b1101, 2'd1, 4'b1101};
    tbl[12] = '{4'b1111, 2'd1, 4'b1101};
    tbl[13] = '{4'b1110, 2'd0, 4'b1110};

    rst  = 1'b1;
    req_ = 4'b1111;
    rdy_ = 1'b1;
    step();
    step();
    check("reset_state", 0, 4'b1110, 1'b1);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_park", 0, 4'b1110, 1'b1);
    end

    rdy_ = 1'b0;
    for (int i = 0; i < 14; i++) begin
      req_ = tbl[i].req_;
      step();
      check($sformatf("vec%0d", i), int'(tbl[i].owner), tbl[i].grnt_, 1'b1);
    end

    // All four requesting, each owner lets go after three cycles of ownership
    for (int k = 0; k <= 4; k++) begin
      req_ = 4'b0000;
      for (int j = 0; j < 2; j++) begin
        step();
        check("rr_hold", k % 4, low_hot(k % 4), 1'b1);
      end
      if (k < 4) begin
        req_ = 4'b0000;
        req_[k % 4] = 1'b1;
        step();
        check("rr_move", (k + 1) % 4, low_hot((k + 1) % 4), 1'b1);
      end
    end

    req_ = 4'b1111;
    step();
    check("park_m0", 0, 4'b1110, 1'b1);
    req_ = 4'b1101;
    step();
    check("grant_m1", 1, 4'b1101, 1'b1);

    // Watchdog expiry with master 3 waiting
    rdy_ = 1'b1;
    req_ = 4'b0101;
    for (int i = 0; i < 7; i++) begin
      step();
      check("wdog_wait_a", 1, 4'b1101, 1'b1);
    end
    step();
    check("wdog_expire_move", 3, 4'b0111, 1'b0);
    rdy_ = 1'b0;
    step();
    check("err_one_cycle", 3, 4'b0111, 1'b1);

    // Watchdog expiry with nobody else requesting
    req_ = 4'b1101;
    step();
    check("regrant_m1", 1, 4'b1101, 1'b1);
    rdy_ = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("wdog_wait_b", 1, 4'b1101, 1'b1);
    end
    step();
    check("wdog_expire_keep", 1, 4'b1101, 1'b0);
    step();
    check("err_clears", 1, 4'b1101, 1'b1);

    // Ready arriving on the would-be expiry edge wins
    rdy_ = 1'b0;
    step();
    check("rdy_clear", 1, 4'b1101, 1'b1);
    rdy_ = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("wdog_wait_c", 1, 4'b1101, 1'b1);
    end
    rdy_ = 1'b0;
    step();
    check("rdy_wins", 1, 4'b1101, 1'b1);
    rdy_ = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check("wdog_restart_wait", 1, 4'b1101, 1'b1);
    end
    step();
    check("wdog_restart_expire", 1, 4'b1101, 1'b0);
    rdy_ = 1'b0;

    // Asynchronous reset while master 2 owns the bus
    req_ = 4'b1011;
    step();
    check("grant_m2", 2, 4'b1011, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("reset_snap", 0, 4'b1110, 1'b1);
    step();
    rst = 1'b0;
    step();
    check("post_reset", 2, 4'b1011, 1'b1);

    n_vec++;
    if (off_err_seen) begin
      n_bad++;
      $display("FAIL timeout0_err: got bus_err_ low at least once, required constant 1");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
